// File: rtl/kuuga_cc_pkg.sv
// Shared types for the Kuuga direct-mapped data cache: FSM states, line record
// and index/tag width derivation.
package kuuga_cc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_MISS_REQ,
      ST_RD_MISS_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT
   } state_t;

   // Tag field is sized for the widest address; stored tags are zero-extended.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] data;
   } line_t;

   function automatic int unsigned idx_w(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned num_lines);
      return addr_w - idx_w(num_lines) - 2;
   endfunction

endpackage

// File: rtl/kuuga_cc_dm_sim_tag_store.sv
// Line storage for the direct-mapped cache: async-cleared valid bits, tag/data
// arrays, combinational lookup and a byte-enabled write port.
module dm_tag_store
   import kuuga_cc_pkg::*;
#(
   parameter int unsigned NUM_LINES = 256,
   parameter int unsigned IDX_W     = 8,
   parameter int unsigned TAG_W     = 22
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] i_rd_idx,
   output line_t            o_rd_line,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0] i_wr_tag,
   input  logic [31:0]      i_wr_data,
   input  logic [3:0]       i_wr_be
);

   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [31:0]          r_data [NUM_LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx] <= i_wr_tag;
         for (int unsigned b = 0; b < 4; b++) begin
            if (i_wr_be[b]) begin
               r_data[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      o_rd_line       = '0;
      o_rd_line.valid = r_valid[i_rd_idx];
      o_rd_line.tag   = 32'(r_tag[i_rd_idx]);
      o_rd_line.data  = r_data[i_rd_idx];
   end

endmodule

// File: rtl/kuuga_cc_dm_sim.sv
// Direct-mapped write-through data cache for the Kuuga core with end-of-run flag.
// Define CACHE_STATS_EN to build the request/hit/miss counters.
module kuuga_cc_dm_sim
   import kuuga_cc_pkg::*;
#(
   parameter int unsigned NUM_LINES = 256,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [3:0]        be_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              done_i,
   output logic              processing_complete_o,
   output logic [31:0]       req_count_o,
   output logic [31:0]       hit_count_o,
   output logic [31:0]       miss_count_o
);

   localparam int unsigned IDX_W = idx_w(NUM_LINES);
   localparam int unsigned TAG_W = tag_w(ADDR_W, NUM_LINES);

   state_t              r_state;
   logic                r_rvalid;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [3:0]          r_mem_be;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_done;

   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   line_t               w_line;
   logic                w_hit;
   logic                w_grant;
   logic                w_wr_en;
   logic [IDX_W-1:0]    w_wr_idx;
   logic [TAG_W-1:0]    w_wr_tag;
   logic [31:0]         w_wr_data;
   logic [3:0]          w_wr_be;

   assign w_idx   = addr_i[IDX_W+1:2];
   assign w_tag   = addr_i[ADDR_W-1:IDX_W+2];
   assign w_hit   = w_line.valid && (w_line.tag == 32'(w_tag));
   assign w_grant = req_i && (r_state == ST_IDLE);

   // Refill (latched miss address) and write-hit merge share the single write port.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_idx  = w_idx;
      w_wr_tag  = w_tag;
      w_wr_data = wdata_i;
      w_wr_be   = be_i;
      if (r_state == ST_RD_MISS_WAIT && mem_rvalid_i) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = r_mem_addr[IDX_W+1:2];
         w_wr_tag  = r_mem_addr[ADDR_W-1:IDX_W+2];
         w_wr_data = mem_rdata_i;
         w_wr_be   = 4'hF;
      end else if (w_grant && we_i && w_hit) begin
         w_wr_en   = 1'b1;
      end
   end

   dm_tag_store #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_idx  (w_idx),
      .o_rd_line (w_line),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_wr_idx),
      .i_wr_tag  (w_wr_tag),
      .i_wr_data (w_wr_data),
      .i_wr_be   (w_wr_be)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rvalid    <= 1'b0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_done      <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_i) begin
                  if (we_i) begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= addr_i;
                     r_mem_be    <= be_i;
                     r_mem_wdata <= wdata_i;
                     r_state     <= ST_WR_REQ;
                  end else if (w_hit) begin
                     r_rvalid <= 1'b1;
                     r_rdata  <= w_line.data;
                  end else begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
                     r_mem_be    <= 4'hF;
                     r_mem_wdata <= '0;
                     r_state     <= ST_RD_MISS_REQ;
                  end
               end else if (done_i) begin
                  r_done <= 1'b1;
               end
            end
            ST_RD_MISS_REQ: begin
               if (mem_gnt_i) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_RD_MISS_WAIT;
               end
            end
            ST_WR_REQ: begin
               if (mem_gnt_i) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_WR_WAIT;
               end
            end
            ST_RD_MISS_WAIT: begin
               if (mem_rvalid_i) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= mem_rdata_i;
                  r_state  <= ST_IDLE;
               end
            end
            ST_WR_WAIT: begin
               if (mem_rvalid_i) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= '0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] r_req_cnt;
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_cnt  <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_grant) begin
         r_req_cnt <= r_req_cnt + 32'd1;
         if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
         else       r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign req_count_o  = r_req_cnt;
   assign hit_count_o  = r_hit_cnt;
   assign miss_count_o = r_miss_cnt;
`else
   assign req_count_o  = '0;
   assign hit_count_o  = '0;
   assign miss_count_o = '0;
`endif

   assign gnt_o                 = w_grant;
   assign rvalid_o              = r_rvalid;
   assign rdata_o               = r_rdata;
   assign mem_req_o             = r_mem_req;
   assign mem_we_o              = r_mem_we;
   assign mem_addr_o            = r_mem_addr;
   assign mem_be_o              = r_mem_be;
   assign mem_wdata_o           = r_mem_wdata;
   assign processing_complete_o = r_done;

endmodule

// File: tb/tb_kuuga_cc_dm_sim.sv
// Directed self-checking bench for kuuga_cc_dm_sim; counter expectations follow
// CACHE_STATS_EN (zero when the macro is undefined).
module tb_kuuga_cc_dm_sim;

`ifdef CACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_i = 1'b0;
   logic        gnt_o;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [3:0]  be_i = '0;
   logic [31:0] wdata_i = '0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        mem_req_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        done_i = 1'b0;
   logic        processing_complete_o;
   logic [31:0] req_count_o;
   logic [31:0] hit_count_o;
   logic [31:0] miss_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   kuuga_cc_dm_sim #(
      .NUM_LINES (256),
      .ADDR_W    (32),
      .DATA_W    (32)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .req_i                 (req_i),
      .gnt_o                 (gnt_o),
      .we_i                  (we_i),
      .addr_i                (addr_i),
      .be_i                  (be_i),
      .wdata_i               (wdata_i),
      .rvalid_o              (rvalid_o),
      .rdata_o               (rdata_o),
      .mem_req_o             (mem_req_o),
      .mem_gnt_i             (mem_gnt_i),
      .mem_we_o              (mem_we_o),
      .mem_addr_o            (mem_addr_o),
      .mem_be_o              (mem_be_o),
      .mem_wdata_o           (mem_wdata_o),
      .mem_rvalid_i          (mem_rvalid_i),
      .mem_rdata_i           (mem_rdata_i),
      .done_i                (done_i),
      .processing_complete_o (processing_complete_o),
      .req_count_o           (req_count_o),
      .hit_count_o           (hit_count_o),
      .miss_count_o          (miss_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input int r, input int h, input int m);
      chk({tag, " req_count"},  req_count_o,  STATS ? 32'(r) : 32'd0);
      chk({tag, " hit_count"},  hit_count_o,  STATS ? 32'(h) : 32'd0);
      chk({tag, " miss_count"}, miss_count_o, STATS ? 32'(m) : 32'd0);
   endtask

   // Read one word; on a miss act as memory with gdly cycles of grant delay.
   task automatic rd(input string tag, input logic [31:0] a, input bit hit,
                     input logic [31:0] md, input logic [31:0] exp, input int gdly);
      logic [31:0] aligned;
      aligned = {a[31:2], 2'b00};
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; addr_i = a; be_i = 4'hF; wdata_i = '0;
      #1 chk({tag, " gnt"}, 32'(gnt_o), 32'd1);
      @(negedge clk);
      req_i = 1'b0; addr_i = 32'hFFFF_FFFC;
      if (hit) begin
         chk({tag, " hit rvalid"}, 32'(rvalid_o), 32'd1);
         chk({tag, " hit rdata"}, rdata_o, exp);
         chk({tag, " hit no mem_req"}, 32'(mem_req_o), 32'd0);
      end else begin
         chk({tag, " mem_req"}, 32'(mem_req_o), 32'd1);
         chk({tag, " mem_addr"}, mem_addr_o, aligned);
         chk({tag, " mem_we"}, 32'(mem_we_o), 32'd0);
         for (int i = 0; i < gdly; i++) begin
            req_i = 1'b1; addr_i = 32'h0000_0040;
            #1 chk({tag, " busy gnt"}, 32'(gnt_o), 32'd0);
            @(negedge clk);
            chk({tag, " held mem_req"}, 32'(mem_req_o), 32'd1);
            chk({tag, " held mem_addr"}, mem_addr_o, aligned);
         end
         req_i = 1'b0;
         mem_gnt_i = 1'b1;
         @(negedge clk);
         mem_gnt_i = 1'b0;
         chk({tag, " mem_req drop"}, 32'(mem_req_o), 32'd0);
         chk({tag, " no early rvalid"}, 32'(rvalid_o), 32'd0);
         mem_rvalid_i = 1'b1; mem_rdata_i = md;
         @(negedge clk);
         mem_rvalid_i = 1'b0; mem_rdata_i = '0;
         chk({tag, " miss rvalid"}, 32'(rvalid_o), 32'd1);
         chk({tag, " miss rdata"}, rdata_o, exp);
      end
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] d);
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; addr_i = a; be_i = be; wdata_i = d;
      #1 chk({tag, " gnt"}, 32'(gnt_o), 32'd1);
      @(negedge clk);
      req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = 32'hFFFF_FFFF;
      chk({tag, " mem_req"}, 32'(mem_req_o), 32'd1);
      chk({tag, " mem_we"}, 32'(mem_we_o), 32'd1);
      chk({tag, " mem_addr"}, mem_addr_o, a);
      chk({tag, " mem_be"}, 32'(mem_be_o), 32'(be));
      chk({tag, " mem_wdata"}, mem_wdata_o, d);
      mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      chk({tag, " mem_req drop"}, 32'(mem_req_o), 32'd0);
      mem_rvalid_i = 1'b1;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      chk({tag, " rvalid"}, 32'(rvalid_o), 32'd1);
      chk({tag, " rdata zero"}, rdata_o, 32'd0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst gnt", 32'(gnt_o), 32'd0);
      chk("rst rvalid", 32'(rvalid_o), 32'd0);
      chk("rst rdata", rdata_o, 32'd0);
      chk("rst mem_req", 32'(mem_req_o), 32'd0);
      chk("rst mem_we", 32'(mem_we_o), 32'd0);
      chk("rst mem_addr", mem_addr_o, 32'd0);
      chk("rst mem_be", 32'(mem_be_o), 32'd0);
      chk("rst mem_wdata", mem_wdata_o, 32'd0);
      chk("rst complete", 32'(processing_complete_o), 32'd0);
      chk_cnt("rst", 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      rd("cold", 32'h0010_0000, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
      chk_cnt("cold", 1, 0, 1);
      rd("rehit", 32'h0010_0000, 1'b1, 32'h0, 32'hDEAD_BEEF, 0);
      chk_cnt("rehit", 2, 1, 1);
      rd("conflict", 32'h0010_0400, 1'b0, 32'h1111_1111, 32'h1111_1111, 0);
      rd("refetch", 32'h0010_0000, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5);
      chk_cnt("refetch", 4, 1, 3);

      rd("fill4", 32'h0010_0004, 1'b0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0);
      wr("wrhit", 32'h0010_0004, 4'b0011, 32'h1234_5678);
      rd("merged", 32'h0010_0004, 1'b1, 32'h0, 32'hAAAA_5678, 0);
      wr("wrmiss", 32'h0010_0008, 4'b1111, 32'hCAFE_F00D);
      rd("noalloc", 32'h0010_0008, 1'b0, 32'h5555_5555, 32'h5555_5555, 0);
      chk_cnt("noalloc", 9, 3, 6);

      // Reset while waiting for the refill, then a stale response arrives.
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0020_0000;
      @(negedge clk);
      req_i = 1'b0; mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst mem_req", 32'(mem_req_o), 32'd0);
      chk("midrst mem_addr", mem_addr_o, 32'd0);
      chk_cnt("midrst", 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h9999_9999;
      @(negedge clk);
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      chk("late rvalid ignored", 32'(rvalid_o), 32'd0);
      chk_cnt("late", 0, 0, 0);
      rd("postrst", 32'h0010_0000, 1'b0, 32'h7777_7777, 32'h7777_7777, 0);
      chk_cnt("postrst", 1, 0, 1);

      // done_i alongside a granted request waits for that request first.
      @(negedge clk);
      done_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0010_0000;
      @(negedge clk);
      req_i = 1'b0;
      chk("done with req", 32'(processing_complete_o), 32'd0);
      chk("done req rdata", rdata_o, 32'h7777_7777);
      @(negedge clk);
      done_i = 1'b0;
      chk("done set", 32'(processing_complete_o), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("done sticky", 32'(processing_complete_o), 32'd1);
      chk_cnt("final", 2, 1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
